enc16to4_pending: RTL and testbench

//   Sequential 16-to-4 request encoder; the reverse direction of the 4-to-16 decoder path.
//   - Captures 16 request lines into a sticky pending register.
//   - Presents the 4-bit index of the winning pending request on a valid/ready handshake.
//   - Clears that request's pending bit on acceptance.
//   - Sits where a decoded one-hot select field must be turned back into a binary index.

---
 rtl/enc16to4_pending_pkg.sv | 19 +
 rtl/enc16to4_pending_prio8.sv | 19 +
 rtl/enc16to4_pending.sv | 88 ++++++++
 tb/tb_enc16to4_pending.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/enc16to4_pending_pkg.sv
// Shared constants for the 16-to-4 pending request encoder.
package enc16to4_pending_pkg;

  localparam int ENC_N = 16;
  localparam int ENC_W = 4;

  // Arbitration modes selected by the PRIO_RR parameter of the top.
  localparam int ENC_PRIO_FIXED = 0;
  localparam int ENC_PRIO_RR    = 1;

  // One-hot decode of a request index, used to clear the accepted bit.
  function automatic logic [ENC_N-1:0] enc_onehot(input logic [ENC_W-1:0] idx);
    logic [ENC_N-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/enc16to4_pending_prio8.sv
// 8-to-3 priority encoder: lowest set index wins, any_o flags a non-zero input.
module enc8to3_prio (
  input  logic [7:0] req_i,
  output logic [2:0] idx_o,
  output logic       any_o
);

  // Scan from the top down so the lowest set bit is the last one to write idx_o.
  always_comb begin
    idx_o = 3'd0;
    any_o = |req_i;
    for (int i = 7; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = 3'(i);
      end
    end
  end

endmodule

// File: rtl/enc16to4_pending.sv
// Sticky 16-line request capture with a valid/ready index output.
// Fixed priority (lowest index) or round-robin from a rotating pointer.
module enc16to4_pending
  import enc16to4_pending_pkg::*;
#(
  parameter int PRIO_RR = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] w,
  output logic [3:0]  y,
  output logic        valid,
  input  logic        ready,
  output logic        ovf
);

  localparam bit RR_MODE = (PRIO_RR == ENC_PRIO_RR);

  logic [ENC_N-1:0] pending_q, pending_d;
  logic [ENC_W-1:0] ptr_q, ptr_d;
  logic             ovf_q, ovf_d;

  logic [ENC_W-1:0]   ptr_eff;
  logic [2*ENC_N-1:0] rot_wide;
  logic [ENC_N-1:0]   rotated;
  logic [2:0]         lo_idx, hi_idx;
  logic               lo_any, hi_any;
  logic [ENC_W-1:0]   rot_idx;
  logic               accept;
  logic [ENC_N-1:0]   clr;
  logic [ENC_N-1:0]   set_vec;

  // Rotate pending right by the search start; fixed priority always starts at 0.
  always_comb begin
    ptr_eff  = RR_MODE ? ptr_q : '0;
    rot_wide = {pending_q, pending_q} >> ptr_eff;
    rotated  = rot_wide[ENC_N-1:0];
  end

  enc8to3_prio u_enc_lo (
    .req_i (rotated[7:0]),
    .idx_o (lo_idx),
    .any_o (lo_any)
  );

  enc8to3_prio u_enc_hi (
    .req_i (rotated[15:8]),
    .idx_o (hi_idx),
    .any_o (hi_any)
  );

  // Merge the two halves, undo the rotation (mod 16) and form the handshake.
  always_comb begin
    rot_idx = lo_any ? {1'b0, lo_idx} : {hi_any, hi_idx};
    valid   = |pending_q;
    y       = valid ? (rot_idx + ptr_eff) : '0;
    accept  = valid & ready;
    clr     = accept ? enc_onehot(y) : '0;
  end

  // Next state: set wins over clear; a duplicate of a still-pending bit raises ovf.
  always_comb begin
    set_vec   = en ? w : '0;
    pending_d = (pending_q & ~clr) | set_vec;
    ovf_d     = ovf_q | (|(set_vec & pending_q & ~clr));
    ptr_d     = ptr_q;
    if (RR_MODE && accept) begin
      ptr_d = y + 4'd1;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      ptr_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      ovf_q     <= ovf_d;
    end
  end

  assign ovf = ovf_q;

endmodule

// File: tb/tb_enc16to4_pending.sv
// Bench for enc16to4_pending: one fixed-priority and one round-robin instance
// share the same stimulus and are compared every cycle against a behavioural model.
module tb_enc16to4_pending;

  logic        clk = 1'b0;
  logic        rst, en, ready;
  logic [15:0] w;
  logic [3:0]  y_fp, y_rr;
  logic        valid_fp, valid_rr, ovf_fp, ovf_rr;

  always #5 clk = ~clk;

  enc16to4_pending #(.PRIO_RR(0)) dut_fp (
    .clk(clk), .rst(rst), .en(en), .w(w),
    .y(y_fp), .valid(valid_fp), .ready(ready), .ovf(ovf_fp)
  );

  enc16to4_pending #(.PRIO_RR(1)) dut_rr (
    .clk(clk), .rst(rst), .en(en), .w(w),
    .y(y_rr), .valid(valid_rr), .ready(ready), .ovf(ovf_rr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state per instance: 0 = fixed priority, 1 = round-robin.
  bit m_pend [2][16];
  int m_ptr  [2];
  bit m_ovf  [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Index of the winning pending request, or -1 when nothing is pending.
  function automatic int m_grant(input int k);
    int base;
    base = (k == 1) ? m_ptr[1] : 0;
    for (int j = 0; j < 16; j++) begin
      if (m_pend[k][(base + j) % 16]) return (base + j) % 16;
    end
    return -1;
  endfunction

  task automatic m_update(input bit r, input bit e, input logic [15:0] ww, input bit rd);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        for (int i = 0; i < 16; i++) m_pend[k][i] = 1'b0;
        m_ptr[k] = 0;
        m_ovf[k] = 1'b0;
      end else begin
        int  g;
        bit  acc;
        g   = m_grant(k);
        acc = (g >= 0) && rd;
        for (int i = 0; i < 16; i++) begin
          bit cl;
          cl = acc && (g == i);
          if (e && ww[i] && m_pend[k][i] && !cl) m_ovf[k] = 1'b1;
          if (cl) m_pend[k][i] = 1'b0;
          if (e && ww[i]) m_pend[k][i] = 1'b1;
        end
        if (k == 1 && acc) m_ptr[1] = (g + 1) % 16;
      end
    end
  endtask

  task automatic m_compare();
    for (int k = 0; k < 2; k++) begin
      int   g;
      logic [3:0] yo;
      logic vo, oo;
      string nm;
      nm = (k == 0) ? "fp" : "rr";
      yo = (k == 0) ? y_fp : y_rr;
      vo = (k == 0) ? valid_fp : valid_rr;
      oo = (k == 0) ? ovf_fp : ovf_rr;
      g  = m_grant(k);
      check({nm, " valid"}, 32'(vo), (g >= 0) ? 32'd1 : 32'd0);
      check({nm, " y"}, 32'(yo), (g >= 0) ? 32'(g) : 32'd0);
      check({nm, " ovf"}, 32'(oo), 32'(m_ovf[k]));
    end
  endtask

  // Apply one cycle of inputs, advance the model across the edge, then compare.
  task automatic tick(input bit r, input bit e, input logic [15:0] ww, input bit rd);
    rst = r; en = e; w = ww; ready = rd;
    @(posedge clk);
    m_update(r, e, ww, rd);
    #1;
    m_compare();
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 16'h0000, 1'b0);
    tick(1'b1, 1'b0, 16'h0000, 1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; w = '0; ready = 1'b0;

    // Reset holds everything clear even with all requests asserted.
    tick(1'b1, 1'b1, 16'hFFFF, 1'b1);
    tick(1'b1, 1'b1, 16'hFFFF, 1'b1);
    check("rst valid", 32'(valid_fp | valid_rr), 32'd0);
    check("rst y", 32'({y_fp, y_rr}), 32'd0);
    check("rst ovf", 32'(ovf_fp | ovf_rr), 32'd0);
    tick(1'b0, 1'b0, 16'h0000, 1'b0);
    check("post rst valid", 32'(valid_fp | valid_rr), 32'd0);

    // Multi-hot burst drained in order 0, 2, 15.
    tick(1'b0, 1'b1, 16'h8005, 1'b1);
    check("burst y0", 32'(y_fp), 32'd0);
    tick(1'b0, 1'b0, 16'h0000, 1'b1);
    check("burst y2", 32'(y_fp), 32'd2);
    tick(1'b0, 1'b0, 16'h0000, 1'b1);
    check("burst y15", 32'(y_fp), 32'd15);
    check("burst rr y15", 32'(y_rr), 32'd15);
    tick(1'b0, 1'b0, 16'h0000, 1'b1);
    check("burst empty", 32'(valid_fp), 32'd0);

    // Back-pressure holds y until accepted.
    do_reset();
    tick(1'b0, 1'b1, 16'h0010, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 16'h0000, 1'b0);
      check("hold y4", 32'(y_fp), 32'd4);
    end
    tick(1'b0, 1'b0, 16'h0000, 1'b1);
    check("hold released", 32'(valid_fp), 32'd0);

    // Duplicate of a still-pending bit sets ovf until reset.
    do_reset();
    tick(1'b0, 1'b1, 16'h0010, 1'b0);
    tick(1'b0, 1'b1, 16'h0010, 1'b0);
    check("ovf set", 32'(ovf_fp), 32'd1);
    tick(1'b0, 1'b0, 16'h0000, 1'b1);
    tick(1'b0, 1'b0, 16'h0000, 1'b0);
    check("ovf sticky", 32'(ovf_fp), 32'd1);

    // Accept and re-request the same bit in one cycle: no ovf, bit re-presented.
    do_reset();
    tick(1'b0, 1'b1, 16'h0010, 1'b0);
    tick(1'b0, 1'b1, 16'h0010, 1'b1);
    check("reacc ovf", 32'(ovf_fp), 32'd0);
    check("reacc y4", 32'({valid_fp, y_fp}), 32'h14);

    // Starvation contrast between fixed priority and round-robin.
    do_reset();
    tick(1'b0, 1'b1, 16'h8003, 1'b1);
    check("starve rr y0", 32'(y_rr), 32'd0);
    tick(1'b0, 1'b1, 16'h0001, 1'b1);
    check("starve rr y1", 32'(y_rr), 32'd1);
    tick(1'b0, 1'b1, 16'h0001, 1'b1);
    check("starve rr y15", 32'(y_rr), 32'd15);
    tick(1'b0, 1'b1, 16'h0001, 1'b1);
    check("starve rr wrap y0", 32'(y_rr), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 16'h0001, 1'b1);
      check("starve fp y0", 32'(y_fp), 32'd0);
      check("starve rr y0", 32'(y_rr), 32'd0);
    end

    // Capture disabled: requests ignored.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 16'hFFFF, 1'(i % 2));
      check("en0 valid", 32'(valid_fp | valid_rr), 32'd0);
      check("en0 ovf", 32'(ovf_fp | ovf_rr), 32'd0);
    end

    // Random traffic with sparse requests, random back-pressure and occasional reset.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [15:0] rw;
      bit r, e, rd;
      rw = 16'($urandom) & 16'($urandom) & 16'($urandom);
      r  = ($urandom_range(0, 59) == 0);
      e  = ($urandom_range(0, 3) != 0);
      rd = ($urandom_range(0, 2) != 0);
      tick(r, e, rw, rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
